// File: rtl/writeback_unit_if.sv
// Memory-stage handshake, load response and register-file write port of the
// write-back stage. The write port also serves as decode's forwarding source.
interface writeback_unit_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_reg_write;
   logic [4:0]  in_rd_addr;
   logic [1:0]  in_wb_sel;
   logic [31:0] in_alu_result;
   logic [31:0] in_pc_plus4;
   logic [2:0]  in_funct3;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        wr_en;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;

   modport master (
      output in_valid, in_reg_write, in_rd_addr, in_wb_sel, in_alu_result,
             in_pc_plus4, in_funct3, mem_rsp_valid, mem_rsp_data,
      input  in_ready, wr_en, rd_addr, rd_data
   );

   modport slave (
      input  in_valid, in_reg_write, in_rd_addr, in_wb_sel, in_alu_result,
             in_pc_plus4, in_funct3, mem_rsp_valid, mem_rsp_data,
      output in_ready, wr_en, rd_addr, rd_data
   );
endinterface

// File: rtl/writeback_unit.sv
// RV32I write-back stage: selects the result, waits for and aligns load data,
// suppresses x0 writes, drives the register-file write port, counts retires.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing to write, ready for a new instruction
// WAIT_LOAD | load accepted, waiting for the memory response
// WRITE     | write port shows the captured result; retires this cycle
module writeback_unit #(
   parameter int INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   writeback_unit_if.slave      wb,
   output logic [INSTRET_W-1:0] instret,
   output logic                 rsp_err
);

   typedef enum logic [1:0] {IDLE, WAIT_LOAD, WRITE} state_t;

   state_t      state, state_nxt;
   logic        accept, is_load;
   logic        wr_en_q;
   logic [4:0]  rd_addr_q;
   logic [31:0] rd_data_q;
   logic        pend_we;
   logic [4:0]  pend_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_addr_lo;
   logic [31:0] sel_val, load_val;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign wb.in_ready = (state != WAIT_LOAD);
   assign accept      = wb.in_valid && wb.in_ready;
   assign is_load     = (wb.in_wb_sel == 2'b01);
   assign wb.wr_en    = wr_en_q;
   assign wb.rd_addr  = rd_addr_q;
   assign wb.rd_data  = rd_data_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LOAD: if (wb.mem_rsp_valid) state_nxt = WRITE;
         default: begin
            if (accept) state_nxt = is_load ? WAIT_LOAD : WRITE;
            else        state_nxt = IDLE;
         end
      endcase
   end

   // Non-load result select; the reserved encoding writes zero.
   always_comb begin
      sel_val = 32'd0;
      case (wb.in_wb_sel)
         2'b00:   sel_val = wb.in_alu_result;
         2'b10:   sel_val = wb.in_pc_plus4;
         default: sel_val = 32'd0;
      endcase
   end

   // Load alignment and extension from the captured size and byte offset.
   always_comb begin
      byte_sel = 8'(wb.mem_rsp_data >> {ld_addr_lo, 3'b000});
      half_sel = ld_addr_lo[1] ? wb.mem_rsp_data[31:16] : wb.mem_rsp_data[15:0];
      load_val = wb.mem_rsp_data;
      case (ld_funct3)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_val = {24'd0, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_val = {16'd0, half_sel};
         default: load_val = wb.mem_rsp_data;
      endcase
   end

   // Capture, write-port registers, retire counter and response error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q    <= 1'b0;
         rd_addr_q  <= 5'd0;
         rd_data_q  <= 32'd0;
         pend_we    <= 1'b0;
         pend_rd    <= 5'd0;
         ld_funct3  <= 3'd0;
         ld_addr_lo <= 2'd0;
         instret    <= '0;
         rsp_err    <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         if (state == WRITE)
            instret <= instret + INSTRET_W'(1);
         if (wb.mem_rsp_valid && state != WAIT_LOAD)
            rsp_err <= 1'b1;
         if (accept) begin
            if (is_load) begin
               pend_we    <= wb.in_reg_write;
               pend_rd    <= wb.in_rd_addr;
               ld_funct3  <= wb.in_funct3;
               ld_addr_lo <= wb.in_alu_result[1:0];
            end else begin
               wr_en_q   <= wb.in_reg_write && (wb.in_rd_addr != 5'd0);
               rd_addr_q <= wb.in_rd_addr;
               rd_data_q <= sel_val;
            end
         end
         if (state == WAIT_LOAD && wb.mem_rsp_valid) begin
            wr_en_q   <= pend_we && (pend_rd != 5'd0);
            rd_addr_q <= pend_rd;
            rd_data_q <= load_val;
         end
      end
   end

endmodule
